// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//   Bus bundle between the three RAM masters (loader, Euler, Step) and the
//   RAM port arbiter, plus the arbiter's RAM-facing outputs.
//
//   Master-side signals (packed, master i at [i*W +: W]):
//     REQ, M_WR_EN        per-master request / write enable
//     M_ADDR_RD_A/RD_B/WR per-master addresses
//     M_DATA_WR           per-master write data
//     GNT                 one-hot registered grant back to the masters
//   RAM-side signals:
//     RAM_WR_Enable, RAM_Address_RD_A/RD_B/WR, RAM_Data_WR
//
//   modport master : the requester side (drives requests, observes grant/RAM)
//   modport slave  : the arbiter
`timescale 1ns/1ps

interface ram_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64,
    parameter int N_MASTERS     = 3
);
    logic [N_MASTERS-1:0]               REQ;
    logic [N_MASTERS-1:0]               GNT;
    logic [N_MASTERS-1:0]               M_WR_EN;
    logic [N_MASTERS*ADDRESS_WIDTH-1:0] M_ADDR_RD_A;
    logic [N_MASTERS*ADDRESS_WIDTH-1:0] M_ADDR_RD_B;
    logic [N_MASTERS*ADDRESS_WIDTH-1:0] M_ADDR_WR;
    logic [N_MASTERS*DATA_WIDTH-1:0]    M_DATA_WR;

    logic                               RAM_WR_Enable;
    logic [ADDRESS_WIDTH-1:0]           RAM_Address_RD_A;
    logic [ADDRESS_WIDTH-1:0]           RAM_Address_RD_B;
    logic [ADDRESS_WIDTH-1:0]           RAM_Address_WR;
    logic [DATA_WIDTH-1:0]              RAM_Data_WR;

    modport master (
        output REQ, M_WR_EN, M_ADDR_RD_A, M_ADDR_RD_B, M_ADDR_WR, M_DATA_WR,
        input  GNT, RAM_WR_Enable, RAM_Address_RD_A, RAM_Address_RD_B,
               RAM_Address_WR, RAM_Data_WR
    );

    modport slave (
        input  REQ, M_WR_EN, M_ADDR_RD_A, M_ADDR_RD_B, M_ADDR_WR, M_DATA_WR,
        output GNT, RAM_WR_Enable, RAM_Address_RD_A, RAM_Address_RD_B,
               RAM_Address_WR, RAM_Data_WR
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single RAM (read ports A/B and one write port) between three
//   masters: 0 = interface loader, 1 = Euler, 2 = Step. Round-robin grant with
//   ownership lock: the granted master keeps the RAM until it drops REQ.
//   After each tenancy one dead TURN cycle drives zero onto the RAM so a write
//   from the old owner can never land in the new owner's tenancy.
//
//   Ports:
//     CLK        in   rising-edge clock
//     RST_N      in   asynchronous active-low reset
//     bus        slave modport of ram_port_arbiter_if (requests, grant,
//                per-master addresses/data, muxed RAM outputs)
//     Arb_Error  out  sticky grant-timeout flag
//
//   Optional feature (macro RAM_ARB_TIMEOUT_EN):
//     defined     -> 13-bit hold counter; an owner holding the RAM for
//                    MAX_HOLD cycles is forced off and Arb_Error is set
//                    (sticky until reset).
//     not defined -> ownership is unbounded and Arb_Error is tied 0.
`timescale 1ns/1ps

module ram_port_arbiter #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64,
    parameter int N_MASTERS     = 3,
    parameter int MAX_HOLD      = 4096
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    ram_port_arbiter_if.slave     bus,
    output logic                  Arb_Error
);

    // The round-robin pick and the 2-bit owner encoding assume three masters;
    // the hold counter is 13 bits wide.
    if (N_MASTERS != 3) begin : g_bad_n_masters
        $error("ram_port_arbiter supports exactly 3 masters");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 8192) begin : g_bad_max_hold
        $error("ram_port_arbiter MAX_HOLD must be in 1..8192");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_TURN = 2'd2
    } state_t;

    // Owner code 3 means "nobody owns the RAM".
    localparam logic [1:0] OWNER_NONE = 2'd3;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [1:0]           owner_q, owner_d;
    logic [1:0]           last_q, last_d;
    logic [1:0]           pick;
    logic                 timeout_hit;

    // First requester after 'last' in the order last+1, last+2, last+3 (mod 3).
    // Scanning from the farthest candidate to the nearest lets the nearest win.
    function automatic logic [1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                           input logic [1:0]           last);
        logic [2:0] s;
        logic [1:0] sel;
        sel = OWNER_NONE;
        for (int k = 3; k >= 1; k--) begin
            s = 3'(last) + 3'(k);
            if (s >= 3'd3) s = s - 3'd3;
            if (req[s[1:0]]) sel = s[1:0];
        end
        return sel;
    endfunction

    assign pick = rr_pick(bus.REQ, last_q);

    // ------------------------------------------------------------------
    // Optional grant timeout
    // ------------------------------------------------------------------
`ifdef RAM_ARB_TIMEOUT_EN
    localparam logic [12:0] HOLD_LAST = 13'(MAX_HOLD - 1);

    logic [12:0] hold_q, hold_d;
    logic        arb_err_q, arb_err_d;

    // Counter is zero outside OWN, so it is already cleared on entry to OWN.
    // Matching HOLD_LAST means this is the MAX_HOLD-th OWN cycle.
    assign timeout_hit = (state_q == S_OWN) && bus.REQ[owner_q] && (hold_q == HOLD_LAST);

    always_comb begin
        hold_d    = (state_q == S_OWN) ? hold_q + 13'd1 : 13'd0;
        arb_err_d = arb_err_q | timeout_hit;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_q    <= 13'd0;
            arb_err_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            arb_err_q <= arb_err_d;
        end
    end

    assign Arb_Error = arb_err_q;
`else
    assign timeout_hit = 1'b0;
    assign Arb_Error   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= OWNER_NONE;
            last_q  <= 2'd2;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (grant is registered, so it is computed here)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (|bus.REQ) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    owner_d     = pick;
                    state_d     = S_OWN;
                end
            end
            S_OWN: begin
                // No preemption: only the owner's own request (or a timeout)
                // ends the tenancy.
                if (!bus.REQ[owner_q] || timeout_hit) begin
                    gnt_d   = '0;
                    last_d  = owner_q;
                    owner_d = OWNER_NONE;
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                owner_d = OWNER_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: combinational mux from the owner register, zero otherwise
    // ------------------------------------------------------------------
    assign bus.GNT = gnt_q;

    always_comb begin
        bus.RAM_WR_Enable    = 1'b0;
        bus.RAM_Address_RD_A = '0;
        bus.RAM_Address_RD_B = '0;
        bus.RAM_Address_WR   = '0;
        bus.RAM_Data_WR      = '0;
        if (state_q == S_OWN && owner_q != OWNER_NONE) begin
            bus.RAM_WR_Enable    = bus.M_WR_EN[owner_q];
            bus.RAM_Address_RD_A = bus.M_ADDR_RD_A[int'(owner_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            bus.RAM_Address_RD_B = bus.M_ADDR_RD_B[int'(owner_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            bus.RAM_Address_WR   = bus.M_ADDR_WR[int'(owner_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            bus.RAM_Data_WR      = bus.M_DATA_WR[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Directed-vector bench for ram_port_arbiter. Inputs are driven and outputs
//   sampled on the falling clock edge; the DUT acts on the rising edge.
//   Master i uses RD_A = 100+i, RD_B = 200+i, WR = 104+i (Step writes 106),
//   write data = 64'h1111_2222_3333_4440 + i.
`timescale 1ns/1ps

module tb_ram_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int NM = 3;

    logic clk;
    logic rst_n;
    logic arb_error;

    int n_vec = 0;
    int n_err = 0;

    ram_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .N_MASTERS(NM)) bus ();

    ram_port_arbiter #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .N_MASTERS    (NM),
        .MAX_HOLD     (8)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .bus      (bus),
        .Arb_Error(arb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] exp_gnt;

        rst_n          = 1'b0;
        bus.REQ        = '0;
        bus.M_WR_EN    = '0;
        for (int i = 0; i < NM; i++) begin
            bus.M_ADDR_RD_A[i*AW +: AW] = 13'(100 + i);
            bus.M_ADDR_RD_B[i*AW +: AW] = 13'(200 + i);
            bus.M_ADDR_WR[i*AW +: AW]   = 13'(104 + i);
            bus.M_DATA_WR[i*DW +: DW]   = 64'h1111_2222_3333_4440 + 64'(i);
        end

        // Reset state: no owner, so all RAM outputs are zero despite live inputs.
        @(negedge clk);
        check_eq("rst_gnt",   64'(bus.GNT), 64'h0);
        check_eq("rst_wren",  64'(bus.RAM_WR_Enable), 64'h0);
        check_eq("rst_rda",   64'(bus.RAM_Address_RD_A), 64'h0);
        check_eq("rst_wra",   64'(bus.RAM_Address_WR), 64'h0);
        check_eq("rst_data",  bus.RAM_Data_WR, 64'h0);
        check_eq("rst_err",   64'(arb_error), 64'h0);
        rst_n = 1'b1;
        tick();

        // Single requester: Euler. Grant one cycle later, addresses muxed.
        bus.REQ = 3'b010;
        check_eq("pre_gnt", 64'(bus.GNT), 64'h0);
        tick();
        check_eq("euler_gnt",  64'(bus.GNT), 64'h2);
        check_eq("euler_rda",  64'(bus.RAM_Address_RD_A), 64'd101);
        check_eq("euler_rdb",  64'(bus.RAM_Address_RD_B), 64'd201);
        check_eq("euler_wra",  64'(bus.RAM_Address_WR), 64'd105);
        check_eq("euler_data", bus.RAM_Data_WR, 64'h1111_2222_3333_4441);
        // Same-cycle follow of the owner's address (combinational path).
        bus.M_ADDR_RD_A[25:13] = 13'd777;
        #1;
        check_eq("euler_rda_follow", 64'(bus.RAM_Address_RD_A), 64'd777);
        bus.M_ADDR_RD_A[25:13] = 13'd101;

        // Step tries to write address 106 while Euler owns: gated out.
        bus.M_WR_EN = 3'b100;
        bus.REQ     = 3'b110;
        tick();
        check_eq("step_wr_gated", 64'(bus.RAM_WR_Enable), 64'h0);
        check_eq("step_wr_addr",  64'(bus.RAM_Address_WR), 64'd105);
        check_eq("no_preempt",    64'(bus.GNT), 64'h2);
        bus.M_WR_EN = 3'b110;
        #1;
        check_eq("euler_wr", 64'(bus.RAM_WR_Enable), 64'h1);
        check_eq("euler_wr_addr", 64'(bus.RAM_Address_WR), 64'd105);

        // Euler drops REQ while still writing: write visible only until the edge.
        bus.REQ = 3'b100;
        #1;
        check_eq("drop_cycle_wr", 64'(bus.RAM_WR_Enable), 64'h1);
        tick();
        check_eq("turn_gnt",  64'(bus.GNT), 64'h0);
        check_eq("turn_wren", 64'(bus.RAM_WR_Enable), 64'h0);
        check_eq("turn_wra",  64'(bus.RAM_Address_WR), 64'h0);
        tick();
        check_eq("idle_gnt",  64'(bus.GNT), 64'h0);
        check_eq("idle_wren", 64'(bus.RAM_WR_Enable), 64'h0);
        tick();
        check_eq("step_gnt",  64'(bus.GNT), 64'h4);
        check_eq("step_wren", 64'(bus.RAM_WR_Enable), 64'h1);
        check_eq("step_wra",  64'(bus.RAM_Address_WR), 64'd106);

        // Release; last owner is Step, so master 0 is first in a 3-way tie.
        bus.REQ     = 3'b000;
        bus.M_WR_EN = 3'b000;
        tick();
        tick();

        // All three request; each owner releases after 5 OWN cycles.
        bus.REQ = 3'b111;
        for (int r = 0; r < 4; r++) begin
            exp_gnt = 3'b001 << (r % 3);
            tick();
            check_eq("rr_gnt", 64'(bus.GNT), 64'(exp_gnt));
            for (int h = 0; h < 4; h++) begin
                tick();
                check_eq("rr_hold", 64'(bus.GNT), 64'(exp_gnt));
            end
            bus.REQ = 3'b111 & ~exp_gnt;
            tick();
            check_eq("rr_turn", 64'(bus.GNT), 64'h0);
            bus.REQ = 3'b111;     // owner re-raises while others still wait
            tick();
            check_eq("rr_idle", 64'(bus.GNT), 64'h0);
        end
        check_eq("rr_err", 64'(arb_error), 64'h0);

        // Last owner was 0, so Euler is next; then an asynchronous reset mid-OWN.
        tick();
        check_eq("pre_rst_gnt", 64'(bus.GNT), 64'h2);
        bus.M_WR_EN = 3'b010;
        #1;
        check_eq("pre_rst_wren", 64'(bus.RAM_WR_Enable), 64'h1);
        #1;
        rst_n = 1'b0;
        #0.5;
        check_eq("async_rst_gnt",  64'(bus.GNT), 64'h0);
        check_eq("async_rst_wren", 64'(bus.RAM_WR_Enable), 64'h0);
        #0.5;
        rst_n = 1'b1;
        bus.M_WR_EN = 3'b000;
        @(negedge clk);
        tick();
        check_eq("post_rst_tie", 64'(bus.GNT), 64'h1);

        // Release, then a REQ pulse that is gone before the next rising edge.
        bus.REQ = 3'b000;
        tick();
        tick();
        bus.REQ = 3'b001;
        #2;
        bus.REQ = 3'b000;
        @(negedge clk);
        check_eq("short_pulse", 64'(bus.GNT), 64'h0);
        tick();
        check_eq("short_pulse2", 64'(bus.GNT), 64'h0);

        // Step holds REQ indefinitely.
        bus.REQ = 3'b100;
        tick();
        check_eq("hold_gnt", 64'(bus.GNT), 64'h4);
`ifdef RAM_ARB_TIMEOUT_EN
        for (int h = 0; h < 7; h++) begin
            tick();
            check_eq("to_hold", 64'(bus.GNT), 64'h4);
            check_eq("to_err_pre", 64'(arb_error), 64'h0);
        end
        tick();
        check_eq("to_drop", 64'(bus.GNT), 64'h0);
        check_eq("to_err",  64'(arb_error), 64'h1);
        tick();
        check_eq("to_idle", 64'(bus.GNT), 64'h0);
        tick();
        check_eq("to_regrant", 64'(bus.GNT), 64'h4);
        check_eq("to_err_sticky", 64'(arb_error), 64'h1);
`else
        for (int h = 0; h < 20; h++) begin
            tick();
            check_eq("unbounded_hold", 64'(bus.GNT), 64'h4);
        end
        check_eq("no_err", 64'(arb_error), 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
